ff_pipe: RTL and testbench
==========================

FF_PIPE -- requirements
Module: ff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per beat (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush_i  input  1  discard all held beats.
REQ-006 SHALL have port valid_i  input  1  upstream beat present.
REQ-007 SHALL have port ready_o  output  1  block accepts upstream beat this cycle.
REQ-008 SHALL have port data_i  input  WIDTH  upstream beat payload.
REQ-009 SHALL have port valid_o  output  1  downstream beat present (last stage valid).
REQ-010 SHALL have port ready_i  input  1  downstream accepts beat.
REQ-011 SHALL have port data_o  output  WIDTH  downstream beat payload (last stage data).
REQ-012 SHALL have, only with FF_PIPE_STATS_EN, port occupancy_o  output  $clog2(DEPTH+1)  count of valid stages.
REQ-013 SHALL have, only with FF_PIPE_STATS_EN, port beats_o  output  32  count of completed output handshakes.

Function
REQ-014 SHALL hold per stage k (0 = input side, DEPTH-1 = output side) one valid bit v[k] and one WIDTH data register d[k].
REQ-015 SHALL define adv[DEPTH-1] = ready_i || !v[DEPTH-1] and adv[k] = adv[k+1] || !v[k] for k < DEPTH-1 (bubble collapsing, combinational).
REQ-016 SHALL drive ready_o = adv[0] && !flush_i.
REQ-017 SHALL on a clock edge with adv[k] true load stage k from stage k-1 (stage 0 from valid_i/data_i qualified by ready_o); stage with adv false holds.
REQ-018 SHALL complete an input handshake when valid_i && ready_o and an output handshake when valid_o && ready_i.
REQ-019 SHALL give DEPTH cycles latency from input handshake to valid_o through an empty pipe with ready_i held high.
REQ-020 SHALL sustain one beat per cycle throughput when ready_i held high.
REQ-021 SHALL keep data_o and valid_o stable while valid_o && !ready_i (no drop, no duplicate, order preserved).
REQ-022 SHALL when full (all v set) and ready_i low drive ready_o low; when full and ready_i high accept and emit in the same cycle.
REQ-023 SHALL on flush_i clear every v[k] at the next edge, accept no input that cycle, data registers unspecified.
REQ-024 SHALL give reset priority over flush_i, flush_i priority over handshakes.

Reset
REQ-025 SHALL on reset clear all v[k] and all d[k] to 0 at the next edge; valid_o = 0 and data_o = 0 after reset.
REQ-026 SHALL drive ready_o = 1 the cycle after reset deasserts (pipe empty, flush_i low).
REQ-027 SHALL on reset mid-stream discard all held beats without emitting them.
REQ-028 SHALL with FF_PIPE_STATS_EN clear occupancy_o and beats_o to 0 on reset; flush_i clears occupancy only.

Configuration
REQ-029 SHALL with FF_PIPE_STATS_EN defined provide occupancy_o (popcount of v) and beats_o (increments per output handshake, wraps 0xFFFFFFFF -> 0).
REQ-030 SHALL without FF_PIPE_STATS_EN omit occupancy_o, beats_o and their logic; handshake behaviour identical.

Verification
REQ-031 SHALL cover: DEPTH=2, ready_i=1, valid_i one cycle data_i=0xA5A5A5A5 -> valid_o high exactly 2 cycles later for 1 cycle, data_o=0xA5A5A5A5.
REQ-032 SHALL cover: DEPTH=3, ready_i=0, stream 0x1,0x2,0x3,0x4 -> 3 accepted, ready_o low on 4th, occupancy_o=3; raise ready_i -> outputs 1,2,3,4 in order.
REQ-033 SHALL cover: continuous valid_i with incrementing data, ready_i=1 -> one output per cycle, no gaps after initial DEPTH latency.
REQ-034 SHALL cover: pipe holding 2 beats, flush_i one cycle while valid_i=1 -> ready_o=0 that cycle, valid_o=0 and occupancy_o=0 next cycle, beat not accepted.
REQ-035 SHALL cover: reset asserted with full pipe and flush_i=1 -> next cycle valid_o=0, data_o=0, beats_o=0; ready_o=1 cycle after release.
REQ-036 SHALL cover: beats_o preloaded by forcing 0xFFFFFFFF, one output handshake -> beats_o=0.

Source files
------------

// File: rtl/ff_pipe.sv
// Elastic register pipeline of DEPTH stages with bubble collapsing and flush.
// Define FF_PIPE_STATS_EN to add the occupancy_o and beats_o statistics outputs.
module ff_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
`ifdef FF_PIPE_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [31:0]                beats_o
`endif
);

  // Handshakes: a beat moves across an interface on a rising edge where both
  // valid and ready are high; valid and data hold until that edge.

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;

  // A stage may advance when the downstream side drains or any later stage is empty.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ready_i || !v[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] || !v[k];
    end
  end

  assign ready_o = adv[0] && !flush_i;
  assign valid_o = v[DEPTH-1];
  assign data_o  = d[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else if (flush_i) begin
      v <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= valid_i;
        if (valid_i) begin
          d[0] <= data_i;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          // Payload only moves with a valid beat so data_o stays quiet between beats.
          if (v[k-1]) begin
            d[k] <= d[k-1];
          end
        end
      end
    end
  end

`ifdef FF_PIPE_STATS_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic [OW-1:0] occ_sum;
  logic [31:0]   beats_q;

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_sum = occ_sum + OW'(v[k]);
    end
  end

  // A beat presented during a flush is discarded, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_q <= '0;
    end else if (!flush_i && valid_o && ready_i) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign occupancy_o = occ_sum;
  assign beats_o     = beats_q;
`endif

endmodule

// File: tb/tb_ff_pipe.sv
// Self-checking bench for ff_pipe: vector table, directed corner cases and
// randomized traffic against a queue-of-positions reference model.
module tb_ff_pipe;
  localparam int W  = 32;
  localparam int D  = 3;
  localparam int OW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset    = 1'b1;
  logic         flush    = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_in  = '0;
  logic         ready_out, valid_out;
  logic [W-1:0] data_out;

  logic         valid_in2 = 1'b0;
  logic         ready_in2 = 1'b0;
  logic [W-1:0] data_in2  = '0;
  logic         ready_out2, valid_out2;
  logic [W-1:0] data_out2;

`ifdef FF_PIPE_STATS_EN
  logic [OW-1:0] occ;
  logic [31:0]   beats;
  logic [1:0]    occ2;
  logic [31:0]   beats2;
`endif

  ff_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
    .data_i(data_in), .valid_o(valid_out), .ready_i(ready_in), .data_o(data_out)
`ifdef FF_PIPE_STATS_EN
    , .occupancy_o(occ), .beats_o(beats)
`endif
  );

  ff_pipe #(.WIDTH(W), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush_i(1'b0), .valid_i(valid_in2), .ready_o(ready_out2),
    .data_i(data_in2), .valid_o(valid_out2), .ready_i(ready_in2), .data_o(data_out2)
`ifdef FF_PIPE_STATS_EN
    , .occupancy_o(occ2), .beats_o(beats2)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           pos_q[$];
  logic [31:0]  exp_beats = '0;

  logic         s_valid, s_ready;
  logic [W-1:0] s_data;
  logic [31:0]  s_occ, s_beats;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_head_valid();
    if (exp_q.size() == 0) return 1'b0;
    return pos_q[0] == D - 1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic vi, input logic [W-1:0] di,
                      input logic ri, input logic fl);
    logic m_valid, m_ready;
    int   lim, np;
    @(negedge clk);
    reset = rst; valid_in = vi; data_in = di; ready_in = ri; flush = fl;
    #1;
    s_valid = valid_out;
    s_ready = ready_out;
    s_data  = data_out;
`ifdef FF_PIPE_STATS_EN
    s_occ   = 32'(occ);
    s_beats = beats;
`else
    s_occ   = '0;
    s_beats = '0;
`endif
    m_valid = model_head_valid();
    m_ready = !fl && (exp_q.size() < D || ri);
    chk("model_valid_o", 32'(s_valid), 32'(m_valid));
    chk("model_ready_o", 32'(s_ready), 32'(m_ready));
    if (m_valid) chk("model_data_o", s_data, exp_q[0]);
`ifdef FF_PIPE_STATS_EN
    chk("model_occupancy_o", s_occ, 32'(exp_q.size()));
    chk("model_beats_o", s_beats, exp_beats);
`endif
    @(posedge clk);
    if (rst) begin
      exp_q.delete(); pos_q.delete(); exp_beats = '0;
    end else if (fl) begin
      exp_q.delete(); pos_q.delete();
    end else begin
      if (m_valid && ri) begin
        void'(exp_q.pop_front()); void'(pos_q.pop_front());
        exp_beats = exp_beats + 32'd1;
      end
      // Each beat moves one slot forward unless the beat ahead of it blocks.
      lim = D - 1;
      foreach (pos_q[i]) begin
        np = pos_q[i] + 1;
        if (np > lim) np = lim;
        pos_q[i] = np;
        lim = np - 1;
      end
      if (vi && m_ready) begin
        exp_q.push_back(di); pos_q.push_back(0);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         vi;
    logic [W-1:0] di;
    logic         ri;
    logic         ev;
    logic [W-1:0] ed;
    logic         er;
    int           eocc;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 0};
    tbl[1] = '{1'b1, 32'd2, 1'b0, 1'b0, 32'd0, 1'b1, 1};
    tbl[2] = '{1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1, 2};
    tbl[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd1, 1'b0, 3};
    tbl[4] = '{1'b1, 32'd4, 1'b1, 1'b1, 32'd1, 1'b1, 3};
    tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 1'b1, 3};
    tbl[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 1'b1, 2};
    tbl[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b1, 1};
    tbl[8] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 0};

    // reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("reset_valid_o", 32'(s_valid), 32'd0);
    chk("reset_data_o", s_data, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // DEPTH=2 latency: one beat appears exactly two cycles later for one cycle
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_in2 = (c == 0);
      data_in2  = (c == 0) ? 32'hA5A5_A5A5 : 32'h0;
      ready_in2 = 1'b1;
      #1;
      if (c == 0) chk("lat2_ready_o", 32'(ready_out2), 32'd1);
      chk("lat2_valid_o", 32'(valid_out2), 32'(c == 2));
      if (c == 2) chk("lat2_data_o", data_out2, 32'hA5A5_A5A5);
    end
    valid_in2 = 1'b0;

    // backpressure table: fill, stall the fourth beat, then drain in order
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].vi, tbl[i].di, tbl[i].ri, 1'b0);
      chk("tbl_valid_o", 32'(s_valid), 32'(tbl[i].ev));
      chk("tbl_ready_o", 32'(s_ready), 32'(tbl[i].er));
      if (tbl[i].ev) chk("tbl_data_o", s_data, tbl[i].ed);
`ifdef FF_PIPE_STATS_EN
      chk("tbl_occupancy_o", s_occ, 32'(tbl[i].eocc));
`endif
    end

    // continuous stream: one output per cycle after DEPTH cycles
    for (int i = 0; i < 15; i++) begin
      step(1'b0, i < 10, 32'(100 + i), 1'b1, 1'b0);
      if (i < D) chk("stream_latency", 32'(s_valid), 32'd0);
      else if (i < D + 10) begin
        chk("stream_valid_o", 32'(s_valid), 32'd1);
        chk("stream_data_o", s_data, 32'(100 + i - D));
      end
    end

    // flush with two held beats while a new beat is offered
    step(1'b0, 1'b1, 32'hAA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hBB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hCC, 1'b0, 1'b1);
    chk("flush_ready_o", 32'(s_ready), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("flush_valid_o", 32'(s_valid), 32'd0);
`ifdef FF_PIPE_STATS_EN
    chk("flush_occupancy_o", s_occ, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("flush_no_leak", 32'(s_valid), 32'd0);
    end

    // reset with a full pipe and flush asserted together
    step(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_full_valid_o", 32'(s_valid), 32'd0);
    chk("rst_full_data_o", s_data, 32'd0);
    chk("rst_full_ready_o", 32'(s_ready), 32'd1);
`ifdef FF_PIPE_STATS_EN
    chk("rst_full_beats_o", s_beats, 32'd0);

    // beat counter wraps from all ones to zero
    force dut.beats_q = 32'hFFFF_FFFF;
    #1;
    release dut.beats_q;
    exp_beats = 32'hFFFF_FFFF;
    step(1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("beats_wrap", s_beats, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic ri, vi, fl, rst;
      ri  = ($urandom_range(0, 3) != 0);
      vi  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if (fl && ri && model_head_valid()) fl = 1'b0;
      step(rst, vi, $urandom, ri, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
